// File: rtl/fu_alu_pipe.sv
// Pipelined integer ALU functional unit with elastic output stages and squash.
// Optional performance counters are compiled in with FU_ALU_PIPE_PERF_EN.
`ifndef XLEN
`define XLEN 32
`endif

package fu_alu_pkg;
   localparam logic [2:0] OPA_IS_RS1  = 3'd0;
   localparam logic [2:0] OPA_IS_NPC  = 3'd1;
   localparam logic [2:0] OPA_IS_PC   = 3'd2;
   localparam logic [2:0] OPA_IS_ZERO = 3'd3;

   localparam logic [2:0] OPB_IS_RS2   = 3'd0;
   localparam logic [2:0] OPB_IS_I_IMM = 3'd1;
   localparam logic [2:0] OPB_IS_S_IMM = 3'd2;
   localparam logic [2:0] OPB_IS_B_IMM = 3'd3;
   localparam logic [2:0] OPB_IS_U_IMM = 3'd4;
   localparam logic [2:0] OPB_IS_J_IMM = 3'd5;

   localparam logic [3:0] ALU_ADD  = 4'd0;
   localparam logic [3:0] ALU_SUB  = 4'd1;
   localparam logic [3:0] ALU_AND  = 4'd2;
   localparam logic [3:0] ALU_OR   = 4'd3;
   localparam logic [3:0] ALU_XOR  = 4'd4;
   localparam logic [3:0] ALU_SLT  = 4'd5;
   localparam logic [3:0] ALU_SLTU = 4'd6;
   localparam logic [3:0] ALU_SLL  = 4'd7;
   localparam logic [3:0] ALU_SRL  = 4'd8;
   localparam logic [3:0] ALU_SRA  = 4'd9;

   typedef struct packed {
      logic [31:0]       inst;
      logic [`XLEN-1:0]  pc;
      logic [`XLEN-1:0]  npc;
      logic [`XLEN-1:0]  rs1_value;
      logic [`XLEN-1:0]  rs2_value;
      logic [2:0]        opa_select;
      logic [2:0]        opb_select;
      logic [3:0]        alu_func;
      logic              rd_mem;
      logic              wr_mem;
      logic              cond_branch;
      logic              uncond_branch;
      logic              halt;
      logic [5:0]        pr_idx;
      logic [4:0]        ar_idx;
      logic [4:0]        rob_idx;
      logic              valid;
   } ISSUE_FU_PACKET;

   typedef struct packed {
      logic [`XLEN-1:0]  dest_value;
      logic              take_branch;
      logic [`XLEN-1:0]  target_pc;
      logic [`XLEN-1:0]  opa;
      logic [`XLEN-1:0]  opb;
      logic              rd_mem;
      logic              wr_mem;
      logic              halt;
      logic [5:0]        pr_idx;
      logic [4:0]        ar_idx;
      logic [4:0]        rob_idx;
      logic              valid;
   } FU_COMPLETE_PACKET;
endpackage

module fu_alu_pipe
   import fu_alu_pkg::*;
#(
   parameter int STAGES = 2,
   parameter int XLEN   = `XLEN
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic              squash,
   input  logic              complete_stall,
   input  ISSUE_FU_PACKET    fu_issue_in,
   output logic              fu_ready,
   output logic              want_to_complete,
   output FU_COMPLETE_PACKET fu_packet_out
`ifdef FU_ALU_PIPE_PERF_EN
   ,
   output logic [31:0]       perf_ops,
   output logic [31:0]       perf_stall_cycles
`endif
);

   function automatic logic [XLEN-1:0] alu(input logic [XLEN-1:0] a,
                                           input logic [XLEN-1:0] b,
                                           input logic [3:0]      func);
      logic signed [XLEN-1:0] sa;
      logic signed [XLEN-1:0] sb;
      sa = a;
      sb = b;
      case (func)
         ALU_ADD:  return a + b;
         ALU_SUB:  return a - b;
         ALU_AND:  return a & b;
         ALU_OR:   return a | b;
         ALU_XOR:  return a ^ b;
         ALU_SLT:  return XLEN'(sa < sb);
         ALU_SLTU: return XLEN'(a < b);
         ALU_SLL:  return a << b[4:0];
         ALU_SRL:  return a >> b[4:0];
         ALU_SRA:  return sa >>> b[4:0];
         default:  return '0;
      endcase
   endfunction

   function automatic logic brcond(input logic [XLEN-1:0] a,
                                   input logic [XLEN-1:0] b,
                                   input logic [2:0]      funct3);
      logic signed [XLEN-1:0] sa;
      logic signed [XLEN-1:0] sb;
      sa = a;
      sb = b;
      case (funct3)
         3'b000:  return a == b;
         3'b001:  return a != b;
         3'b100:  return sa < sb;
         3'b101:  return sa >= sb;
         3'b110:  return a < b;
         3'b111:  return a >= b;
         default: return 1'b0;
      endcase
   endfunction

   logic [31:0]       inst;
   logic [XLEN-1:0]   opa;
   logic [XLEN-1:0]   opb;
   logic [XLEN-1:0]   dest_value;
   logic              is_branch;
   logic              accept;
   logic              unused_opcode;
   FU_COMPLETE_PACKET comp_pkt;

   logic              vld_p  [STAGES];
   logic              load_p [STAGES];
   FU_COMPLETE_PACKET pkt_p  [STAGES];

   assign inst          = fu_issue_in.inst;
   assign unused_opcode = ^inst[6:0];

   always_comb begin
      case (fu_issue_in.opa_select)
         OPA_IS_RS1:  opa = fu_issue_in.rs1_value;
         OPA_IS_NPC:  opa = fu_issue_in.npc;
         OPA_IS_PC:   opa = fu_issue_in.pc;
         OPA_IS_ZERO: opa = '0;
         default:     opa = XLEN'(32'hdeadfbac);
      endcase
      case (fu_issue_in.opb_select)
         OPB_IS_RS2:   opb = fu_issue_in.rs2_value;
         OPB_IS_I_IMM: opb = {{(XLEN-12){inst[31]}}, inst[31:20]};
         OPB_IS_S_IMM: opb = {{(XLEN-12){inst[31]}}, inst[31:25], inst[11:7]};
         OPB_IS_B_IMM: opb = {{(XLEN-13){inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
         OPB_IS_U_IMM: opb = XLEN'($signed({inst[31:12], 12'b0}));
         OPB_IS_J_IMM: opb = {{(XLEN-21){inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
         default:      opb = XLEN'(32'hfacefeed);
      endcase
      dest_value = alu(opa, opb, fu_issue_in.alu_func);
      is_branch  = fu_issue_in.cond_branch | fu_issue_in.uncond_branch;

      comp_pkt             = '0;
      comp_pkt.dest_value  = dest_value;
      comp_pkt.take_branch = fu_issue_in.uncond_branch |
                             (fu_issue_in.cond_branch &
                              brcond(fu_issue_in.rs1_value, fu_issue_in.rs2_value, inst[14:12]));
      comp_pkt.target_pc   = is_branch ? dest_value : '0;
      comp_pkt.opa         = opa;
      comp_pkt.opb         = fu_issue_in.rs2_value;
      comp_pkt.rd_mem      = fu_issue_in.rd_mem;
      comp_pkt.wr_mem      = fu_issue_in.wr_mem;
      comp_pkt.halt        = fu_issue_in.halt;
      comp_pkt.pr_idx      = fu_issue_in.pr_idx;
      comp_pkt.ar_idx      = fu_issue_in.ar_idx;
      comp_pkt.rob_idx     = fu_issue_in.rob_idx;
      comp_pkt.valid       = fu_issue_in.valid;
   end

   // A stage loads when its current occupant leaves or it is empty; bubbles collapse.
   always_comb begin
      logic go;
      go = !vld_p[STAGES-1] | !complete_stall;
      load_p[STAGES-1] = go;
      for (int i = STAGES - 2; i >= 0; i--) begin
         go        = !vld_p[i] | go;
         load_p[i] = go;
      end
   end

   assign fu_ready = load_p[0];
   assign accept   = fu_issue_in.valid & fu_ready;

   // Stage boundary: issue -> stage 0 -> ... -> output stage
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < STAGES; i++) begin
            vld_p[i] <= 1'b0;
            pkt_p[i] <= '0;
         end
      end else begin
         if (squash) begin
            for (int i = 0; i < STAGES; i++) vld_p[i] <= 1'b0;
         end else begin
            if (load_p[0]) vld_p[0] <= accept;
            for (int i = 1; i < STAGES; i++) begin
               if (load_p[i]) vld_p[i] <= vld_p[i-1];
            end
         end
         if (load_p[0]) pkt_p[0] <= comp_pkt;
         for (int i = 1; i < STAGES; i++) begin
            if (load_p[i]) pkt_p[i] <= pkt_p[i-1];
         end
      end
   end

   always_comb begin
      fu_packet_out       = pkt_p[STAGES-1];
      fu_packet_out.valid = vld_p[STAGES-1];
   end

   assign want_to_complete = vld_p[STAGES-1];

`ifdef FU_ALU_PIPE_PERF_EN
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         perf_ops          <= '0;
         perf_stall_cycles <= '0;
      end else begin
         if (accept) perf_ops <= perf_ops + 32'd1;
         if (want_to_complete & complete_stall) perf_stall_cycles <= perf_stall_cycles + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_fu_alu_pipe.sv
// Scoreboard bench for fu_alu_pipe: directed cases plus randomized traffic with stalls and squashes.
module tb_fu_alu_pipe;
   import fu_alu_pkg::*;

   localparam int STAGES = 2;

   logic              clock = 1'b0;
   logic              reset_n;
   logic              squash;
   logic              complete_stall;
   ISSUE_FU_PACKET    issue;
   logic              fu_ready;
   logic              want;
   FU_COMPLETE_PACKET pkt_out;
`ifdef FU_ALU_PIPE_PERF_EN
   logic [31:0]       perf_ops;
   logic [31:0]       perf_stall_cycles;
`endif

   fu_alu_pipe #(.STAGES(STAGES), .XLEN(32)) dut (
      .clock            (clock),
      .reset_n          (reset_n),
      .squash           (squash),
      .complete_stall   (complete_stall),
      .fu_issue_in      (issue),
      .fu_ready         (fu_ready),
      .want_to_complete (want),
      .fu_packet_out    (pkt_out)
`ifdef FU_ALU_PIPE_PERF_EN
      ,
      .perf_ops         (perf_ops),
      .perf_stall_cycles(perf_stall_cycles)
`endif
   );

   always #5 clock = ~clock;

   int n_vec = 0;
   int n_err = 0;
   int exp_ops = 0;
   int exp_stall = 0;
   FU_COMPLETE_PACKET exp_q[$];

   function automatic void chk(input string nm, input logic [191:0] act, input logic [191:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endfunction

   // Reference: the result an op must produce, straight from the ISA-level rules.
   function automatic FU_COMPLETE_PACKET model(input ISSUE_FU_PACKET op);
      FU_COMPLETE_PACKET r;
      logic [31:0] a, b, i, res;
      int imm, sa, sb;
      bit br;
      i = op.inst;
      case (op.opa_select)
         3'd0: a = op.rs1_value;
         3'd1: a = op.npc;
         3'd2: a = op.pc;
         3'd3: a = 0;
         default: a = 32'hdeadfbac;
      endcase
      case (op.opb_select)
         3'd0: b = op.rs2_value;
         3'd1: begin imm = $signed(i[31:20]); b = imm; end
         3'd2: begin imm = $signed({i[31:25], i[11:7]}); b = imm; end
         3'd3: begin imm = $signed({i[31], i[7], i[30:25], i[11:8], 1'b0}); b = imm; end
         3'd4: b = {i[31:12], 12'h000};
         3'd5: begin imm = $signed({i[31], i[19:12], i[20], i[30:21], 1'b0}); b = imm; end
         default: b = 32'hfacefeed;
      endcase
      sa = a;
      sb = b;
      case (op.alu_func)
         4'd0: res = a + b;
         4'd1: res = a - b;
         4'd2: res = a & b;
         4'd3: res = a | b;
         4'd4: res = a ^ b;
         4'd5: res = (sa < sb) ? 1 : 0;
         4'd6: res = (a < b) ? 1 : 0;
         4'd7: res = a << b[4:0];
         4'd8: res = a >> b[4:0];
         4'd9: res = sa >>> b[4:0];
         default: res = 0;
      endcase
      sa = op.rs1_value;
      sb = op.rs2_value;
      case (i[14:12])
         3'b000: br = op.rs1_value == op.rs2_value;
         3'b001: br = op.rs1_value != op.rs2_value;
         3'b100: br = sa < sb;
         3'b101: br = sa >= sb;
         3'b110: br = op.rs1_value < op.rs2_value;
         3'b111: br = op.rs1_value >= op.rs2_value;
         default: br = 0;
      endcase
      r = '0;
      r.dest_value  = res;
      r.take_branch = op.uncond_branch | (op.cond_branch & br);
      r.target_pc   = (op.cond_branch | op.uncond_branch) ? res : 0;
      r.opa         = a;
      r.opb         = op.rs2_value;
      r.rd_mem      = op.rd_mem;
      r.wr_mem      = op.wr_mem;
      r.halt        = op.halt;
      r.pr_idx      = op.pr_idx;
      r.ar_idx      = op.ar_idx;
      r.rob_idx     = op.rob_idx;
      r.valid       = 1'b1;
      return r;
   endfunction

   function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [2:0] f3);
      return {imm[12], imm[10:5], 5'd2, 5'd1, f3, imm[4:1], imm[11], 7'b1100011};
   endfunction

   int tag = 0;
   function automatic ISSUE_FU_PACKET mk_op(input logic [31:0] rs1, input logic [31:0] rs2,
                                            input logic [2:0] asel, input logic [2:0] bsel,
                                            input logic [3:0] func);
      ISSUE_FU_PACKET op;
      op = '0;
      op.rs1_value  = rs1;
      op.rs2_value  = rs2;
      op.opa_select = asel;
      op.opb_select = bsel;
      op.alu_func   = func;
      op.rob_idx    = 5'(tag);
      op.pr_idx     = 6'(tag + 3);
      op.ar_idx     = 5'(tag + 7);
      tag++;
      op.valid      = 1'b1;
      return op;
   endfunction

   function automatic ISSUE_FU_PACKET rand_op();
      ISSUE_FU_PACKET op;
      op = '0;
      op.inst          = $urandom;
      op.pc            = $urandom;
      op.npc           = op.pc + 4;
      op.rs1_value     = $urandom;
      op.rs2_value     = ($urandom_range(0, 3) == 0) ? op.rs1_value : $urandom;
      op.opa_select    = 3'($urandom_range(0, 4));
      op.opb_select    = 3'($urandom_range(0, 6));
      op.alu_func      = 4'($urandom_range(0, 10));
      op.rd_mem        = 1'($urandom_range(0, 1));
      op.wr_mem        = 1'($urandom_range(0, 1));
      op.cond_branch   = 1'($urandom_range(0, 1));
      op.uncond_branch = ($urandom_range(0, 4) == 0);
      op.halt          = ($urandom_range(0, 9) == 0);
      op.pr_idx        = 6'($urandom);
      op.ar_idx        = 5'($urandom);
      op.rob_idx       = 5'($urandom);
      op.valid         = 1'b1;
      return op;
   endfunction

   // Monitor: every presented output must match the oldest outstanding op.
   always @(negedge clock) begin
      if (reset_n === 1'b1) begin
         if (want) begin
            if (exp_q.size() == 0) begin
               n_vec++;
               n_err++;
               $display("FAIL unexpected_output: got rob_idx %0d with valid=1, required no output", pkt_out.rob_idx);
            end else begin
               chk("out_pkt", pkt_out, exp_q[0]);
               if (!complete_stall) void'(exp_q.pop_front());
            end
            if (complete_stall) exp_stall++;
         end
         if (squash) exp_q.delete();
      end
   end

   task automatic send(input ISSUE_FU_PACKET op);
      bit done;
      done = 0;
      issue = op;
      issue.valid = 1'b1;
      for (int k = 0; k < 50 && !done; k++) begin
         @(negedge clock);
         if (fu_ready) begin
            exp_ops++;
            if (!squash) exp_q.push_back(model(issue));
            done = 1;
         end
      end
      if (!done) begin
         n_vec++;
         n_err++;
         $display("FAIL send_timeout: fu_ready=%0b, required 1 within 50 cycles", fu_ready);
      end
      @(posedge clock);
      #1;
      issue.valid = 1'b0;
   endtask

   task automatic wait_out(input string nm);
      bit seen;
      seen = 0;
      for (int k = 0; k < 20 && !seen; k++) begin
         @(negedge clock);
         seen = want;
      end
      if (!seen) begin
         n_vec++;
         n_err++;
         $display("FAIL %s_timeout: want_to_complete=0, required 1 within 20 cycles", nm);
      end
   endtask

   initial begin
      ISSUE_FU_PACKET op, cur;
      bit pending;
      reset_n = 1'b0;
      squash = 1'b0;
      complete_stall = 1'b0;
      issue = '0;
      cur = '0;
      pending = 0;

      // reset state
      @(negedge clock);
      chk("reset_want", want, 0);
      chk("reset_pkt", pkt_out, 0);
      #2 reset_n = 1'b1;
      @(negedge clock);
      chk("reset_ready", fu_ready, 1);
      @(posedge clock);
      #1;

      // ADD latency and result
      send(mk_op(5, 7, OPA_IS_RS1, OPB_IS_RS2, ALU_ADD));
      for (int k = 0; k < STAGES - 1; k++) begin
         @(negedge clock);
         chk("add_early", want, 0);
      end
      @(negedge clock);
      chk("add_latency", want, 1);
      chk("add_dest", pkt_out.dest_value, 12);
      chk("add_take", pkt_out.take_branch, 0);
      chk("add_target", pkt_out.target_pc, 0);
      @(posedge clock);
      #1;

      // BEQ taken and not taken
      op = mk_op(9, 9, OPA_IS_PC, OPB_IS_B_IMM, ALU_ADD);
      op.pc = 32'h100;
      op.npc = 32'h104;
      op.inst = enc_b(13'd16, 3'b000);
      op.cond_branch = 1'b1;
      send(op);
      wait_out("beq_t");
      chk("beq_take", pkt_out.take_branch, 1);
      chk("beq_target", pkt_out.target_pc, 32'h110);
      @(posedge clock);
      #1;
      op.rs2_value = 8;
      send(op);
      wait_out("beq_nt");
      chk("beq_nt_take", pkt_out.take_branch, 0);
      chk("beq_nt_target", pkt_out.target_pc, 32'h110);
      @(posedge clock);
      #1;

      // illegal operand selects
      send(mk_op(32'h55, 32'h1234, 3'd7, 3'd7, ALU_ADD));
      wait_out("illegal");
      chk("illegal_opa", pkt_out.opa, 32'hdeadfbac);
      chk("illegal_opb", pkt_out.opb, 32'h1234);
      chk("illegal_dest", pkt_out.dest_value, 32'hd97cfa99);
      @(posedge clock);
      #1;

      // back-to-back ops with a held stall, then release
      fork
         begin
            for (int k = 0; k < 4; k++) send(mk_op(k, 100 + k, OPA_IS_RS1, OPB_IS_RS2, ALU_SUB));
         end
         begin
            repeat (3) @(posedge clock);
            #1 complete_stall = 1'b1;
            repeat (3) @(negedge clock);
            chk("full_ready", fu_ready, 0);
            chk("full_want", want, 1);
            @(negedge clock);
            chk("full_ready_hold", fu_ready, 0);
            @(posedge clock);
            #1 complete_stall = 1'b0;
            @(negedge clock);
            chk("release_ready", fu_ready, 1);
         end
      join
      for (int k = 0; k < 20 && exp_q.size() != 0; k++) @(negedge clock);
      chk("stall_drain", exp_q.size(), 0);
      @(posedge clock);
      #1;

      // squash with an op presented in the same cycle
      send(mk_op(1, 2, OPA_IS_RS1, OPB_IS_RS2, ALU_XOR));
      send(mk_op(3, 4, OPA_IS_RS1, OPB_IS_RS2, ALU_OR));
      issue = mk_op(5, 6, OPA_IS_RS1, OPB_IS_RS2, ALU_ADD);
      squash = 1'b1;
      @(negedge clock);
      chk("squash_cycle_ready", fu_ready, 1);
      if (fu_ready) exp_ops++;
      @(posedge clock);
      #1;
      squash = 1'b0;
      issue.valid = 1'b0;
      @(negedge clock);
      chk("squash_want", want, 0);
      chk("squash_ready", fu_ready, 1);
      repeat (4) @(negedge clock);
      chk("squash_quiet", want, 0);
      @(posedge clock);
      #1;

      // asynchronous reset with ops in flight
      send(mk_op(11, 12, OPA_IS_RS1, OPB_IS_RS2, ALU_ADD));
      send(mk_op(13, 14, OPA_IS_RS1, OPB_IS_RS2, ALU_ADD));
      #2 reset_n = 1'b0;
      #1;
      chk("areset_want", want, 0);
      chk("areset_pkt", pkt_out, 0);
      exp_q.delete();
      exp_ops = 0;
      exp_stall = 0;
`ifdef FU_ALU_PIPE_PERF_EN
      chk("areset_perf_ops", perf_ops, 0);
      chk("areset_perf_stall", perf_stall_cycles, 0);
`endif
      #3 reset_n = 1'b1;
      repeat (4) @(negedge clock);
      chk("areset_quiet", want, 0);
      @(posedge clock);
      #1;
      send(mk_op(5, 7, OPA_IS_RS1, OPB_IS_RS2, ALU_ADD));
      wait_out("post_reset");
      chk("post_reset_dest", pkt_out.dest_value, 12);
      @(posedge clock);
      #1;

      // randomized traffic with stalls and occasional squash
      for (int c = 0; c < 800; c++) begin
         complete_stall = ($urandom_range(0, 3) == 0);
         squash = ($urandom_range(0, 39) == 0);
         if (!pending && $urandom_range(0, 3) != 0) begin
            cur = rand_op();
            pending = 1;
         end
         issue = cur;
         issue.valid = pending;
         @(negedge clock);
         if (pending && fu_ready) begin
            exp_ops++;
            if (!squash) exp_q.push_back(model(issue));
            pending = 0;
         end
         @(posedge clock);
         #1;
      end
      complete_stall = 1'b0;
      squash = 1'b0;
      issue.valid = 1'b0;
      for (int k = 0; k < 40 && exp_q.size() != 0; k++) @(negedge clock);
      chk("final_drain", exp_q.size(), 0);
      repeat (4) @(negedge clock);
      chk("final_quiet", want, 0);
`ifdef FU_ALU_PIPE_PERF_EN
      chk("perf_ops", perf_ops, 32'(exp_ops));
      chk("perf_stall_cycles", perf_stall_cycles, 32'(exp_stall));
`endif
      $display("model counts: accepted=%0d stall_cycles=%0d", exp_ops, exp_stall);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
